// File: rtl/nx_pkg.sv
// nx_pkg: shared message types, header layout constants and instruction width helper
package nx_pkg;
  typedef enum logic [1:0] {MSG_LOAD, MSG_SIGNAL, MSG_RSVD2, MSG_RSVD3} msg_type_t;
  localparam int TYPE_W = 2;
  localparam int BCAST_W = 1;
  localparam int TYPE_OFF = 0;
  localparam int BCAST_OFF = TYPE_OFF + TYPE_W;
  localparam int COL_OFF = BCAST_OFF + BCAST_W;
  function automatic int hdr_w(input int row_w, input int col_w);
    return row_w + col_w + BCAST_W + TYPE_W;
  endfunction
  function automatic int inst_w(input int op_w, input int reg_w, input int io_w);
    return op_w + 3 * $clog2(reg_w) + 1 + $clog2(io_w);
  endfunction
endpackage

// File: rtl/nx_msg_fifo.sv
// nx_msg_fifo: 2-entry message FIFO with push/pop and full/empty status
module nx_msg_fifo #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  logic [W-1:0] mem [2];
  logic         rd_ptr, wr_ptr;
  logic [1:0]   cnt;
  assign full = cnt == 2'd2;
  assign empty = cnt == 2'd0;
  assign dout = mem[rd_ptr];
  // storage is data-only, written at the tail on push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers and occupancy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/nx_node_decoder.sv
// nx_node_decoder: decodes inbound mesh messages into core strobes; bypass forwarding under NX_DECODER_BYPASS_EN
module nx_node_decoder import nx_pkg::*; #(
  parameter int OP_W = 4,
  parameter int REG_W = 16,
  parameter int IO_W = 4,
  parameter int SLOTS = 32,
  parameter int ADDR_ROW_W = 4,
  parameter int ADDR_COL_W = 4,
  parameter int MSG_W = 40,
  localparam int INST_W = inst_w(OP_W, REG_W, IO_W),
  localparam int SLOT_W = $clog2(SLOTS),
  localparam int IDX_W = $clog2(IO_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_ROW_W-1:0] node_row,
  input  logic [ADDR_COL_W-1:0] node_col,
  input  logic [MSG_W-1:0]      msg_data,
  input  logic                  msg_valid,
  output logic                  msg_ready,
  output logic [MSG_W-1:0]      byp_data,
  output logic                  byp_valid,
  input  logic                  byp_ready,
  input  logic                  core_in_setup,
  output logic [INST_W-1:0]     load_instr,
  output logic [SLOT_W-1:0]     load_slot,
  output logic                  load_last,
  output logic                  load_valid,
  output logic                  in_value,
  output logic [IDX_W-1:0]      in_index,
  output logic                  in_valid,
  output logic                  err_load
);
  localparam int HDR_W = hdr_w(ADDR_ROW_W, ADDR_COL_W);
  logic [MSG_W-1:0]      head;
  logic                  full, empty, pop, hit, is_local, ld_ok, ld_drop, sg;
  logic [ADDR_ROW_W-1:0] row;
  logic [ADDR_COL_W-1:0] col;
  logic                  bcast;
  msg_type_t             typ;
  logic                  unused;
  nx_msg_fifo #(.W(MSG_W)) u_fifo (
    .clk(clk), .rst(rst), .push(msg_valid & msg_ready), .pop(pop),
    .din(msg_data), .dout(head), .full(full), .empty(empty)
  );
  assign msg_ready = ~full;
  assign row = head[MSG_W-1 -: ADDR_ROW_W];
  assign col = head[MSG_W-HDR_W+COL_OFF +: ADDR_COL_W];
  assign bcast = head[MSG_W-HDR_W+BCAST_OFF];
  assign typ = msg_type_t'(head[MSG_W-HDR_W+TYPE_OFF +: TYPE_W]);
  assign hit = row == node_row && col == node_col;
  assign is_local = bcast | hit;
  assign ld_ok = pop & is_local & typ == MSG_LOAD & core_in_setup;
  assign ld_drop = pop & is_local & typ == MSG_LOAD & ~core_in_setup;
  assign sg = pop & is_local & typ == MSG_SIGNAL;
`ifdef NX_DECODER_BYPASS_EN
  logic fwd;
  assign fwd = bcast | ~hit;
  assign pop = ~empty & (~fwd | ~byp_valid | byp_ready);
  assign unused = ^head;
  // bypass register: load on forwarding pop, hold while downstream stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      byp_valid <= 1'b0;
      byp_data <= '0;
    end else if (pop & fwd) begin
      byp_valid <= 1'b1;
      byp_data <= head;
    end else if (byp_ready) byp_valid <= 1'b0;
`else
  assign pop = ~empty;
  assign byp_valid = 1'b0;
  assign byp_data = '0;
  assign unused = ^{head, byp_ready};
`endif
  // single-cycle core strobes, their fields, and the sticky dropped-load flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      load_valid <= 1'b0;
      load_instr <= '0;
      load_slot <= '0;
      load_last <= 1'b0;
      in_valid <= 1'b0;
      in_value <= 1'b0;
      in_index <= '0;
      err_load <= 1'b0;
    end else begin
      load_valid <= ld_ok;
      in_valid <= sg;
      err_load <= err_load | ld_drop;
      if (ld_ok) begin
        load_instr <= head[INST_W-1:0];
        load_slot <= head[INST_W +: SLOT_W];
        load_last <= head[INST_W+SLOT_W];
      end
      if (sg) begin
        in_value <= head[0];
        in_index <= head[1 +: IDX_W];
      end
    end
endmodule

// File: doc/nx_node_decoder.md
# nx_node_decoder

Inbound message decoder placed directly upstream of the node core inside each mesh node. It accepts fixed-width messages from the mesh through a valid/ready handshake and buffers them in a 2-entry FIFO. It matches each message's row/column address against the node's own position, then turns local messages into single-cycle instruction-load or input-signal strobes for the core. Messages addressed elsewhere, and broadcasts, are forwarded on a registered bypass port toward the next node.

## Interface
- OP_W, 4, operation encoding width (sizes instruction).
- REG_W, 16, core register count (sizes instruction).
- IO_W, 4, core primary I/O count.
- SLOTS, 32, core instruction slots.
- ADDR_ROW_W, 4, row address width.
- ADDR_COL_W, 4, column address width.
- MSG_W, 40, message width; must be at least header + largest payload.
- INST_W, derived, OP_W + 3*$clog2(REG_W) + 1 + $clog2(IO_W).
- clk  in  1  clock.
- rst  in  1  reset: asynchronous, active-high.
- node_row  in  ADDR_ROW_W  this node's row; static after reset.
- node_col  in  ADDR_COL_W  this node's column; static after reset.
- msg_data  in  MSG_W  inbound message.
- msg_valid  in  1  inbound message valid.
- msg_ready  out  1  decoder can accept a message.
- byp_data  out  MSG_W  forwarded message.
- byp_valid  out  1  forwarded message valid.
- byp_ready  in  1  downstream accepts the forwarded message.
- core_in_setup  in  1  core is in its SETUP state.
- load_instr  out  INST_W  instruction to store.
- load_slot  out  $clog2(SLOTS)  target slot.
- load_last  out  1  final instruction of the program.
- load_valid  out  1  instruction strobe.
- in_value  out  1  input bit value.
- in_index  out  $clog2(IO_W)  input bit index.
- in_valid  out  1  input strobe.
- err_load  out  1  sticky flag: an instruction load was dropped.

## Operation
- Message layout, MSB first: row[ADDR_ROW_W], col[ADDR_COL_W], bcast[1], type[2], then the payload, right-aligned at bit 0. Unused middle bits are ignored.
- Type 0, LOAD: payload is {last, slot, instr}.
- Type 1, SIGNAL: payload is {index, value}.
- Types 2 and 3 are reserved: consumed and discarded, with no other effect.
- A message is local when bcast=1, or when row==node_row and col==node_col.
- Local LOAD:
  - if core_in_setup=1, pulse load_valid with its fields;
  - otherwise drop it and set err_load.
  - err_load clears only on rst.
- Local SIGNAL: pulse in_valid in any core state.
- Non-local message, or bcast=1: forward the message unmodified to the bypass register.
- FIFO: 2 entries. msg_ready = (count < 2), taken from registered state only. A push when full cannot occur.
- The FIFO head pops when both hold:
  - its local action (if any) can be performed; local actions are always performable;
  - its forward action (if any) has the bypass register empty, or draining this cycle (byp_valid & byp_ready).
- At most one pop per cycle. Push and pop may coincide at any count.
- Bypass register: loads on pop; holds data stable while byp_valid=1 and byp_ready=0.

## Timing
- Reset values: msg_ready=1, byp_valid=0, byp_data=0, load_valid=0, in_valid=0, all strobe fields 0, err_load=0. The FIFO is emptied.
- Strobes are registered and last exactly one cycle; at most one of load_valid and in_valid is asserted per cycle.
- Latency: a message accepted on edge E, with an unblocked head, produces its strobe and/or byp_valid in the cycle after edge E+1.
- Sustained throughput is 1 message per cycle while nothing is stalled.
- A stalled bypass blocks the head, which may be a broadcast or non-local message. Local messages behind it wait; there is no reordering.
- A reset mid-operation discards FIFO contents and any pending bypass message.

## Configuration
- NX_DECODER_BYPASS_EN
  - Defined: behaviour as above.
  - Undefined: the bypass register and its logic are removed. byp_valid is tied 0 and byp_data is tied 0. byp_ready is ignored. Non-local messages are consumed and discarded in one cycle. Broadcasts act locally only.

## Structure
- Shared package nx_pkg holds:
  - the message type enum (LOAD, SIGNAL, RSVD2, RSVD3);
  - header field width and offset constants;
  - the INST_W calculation function.
- Sub-module nx_msg_fifo: parameterised width, depth 2, push/pop, full/empty outputs.

## Test plan
- Reset, then with node=(1,2) and core_in_setup=1, send LOAD (row1, col2, slot 5, last 1, instr 0x1234A). Expect exactly one load_valid cycle with slot=5, last=1, instr=0x1234A, 2 cycles after acceptance.
- With core_in_setup=0, send a local LOAD. Expect no load_valid and err_load=1, held until rst.
- Send SIGNAL (index 3, value 1) to (1,2). Expect in_valid=1, in_index=3, in_value=1 for one cycle.
- Hold byp_ready=0 and send 3 messages to (0,0). Expect byp_valid asserted with data held; msg_ready drops to 0 once the FIFO is full; all 3 drain in order after byp_ready=1.
- Send a broadcast SIGNAL with byp_ready=1. Expect in_valid and byp_valid in the same cycle. Without NX_DECODER_BYPASS_EN, expect in_valid only and byp_valid stays 0.
